// File: rtl/sseg_score_display.sv
// Four-digit seven-segment score driver: player 1 on the left pair, player 2 on the right pair.
// Optional post-change blink of a player's digit pair is compiled in with SSEG_SCORE_BLINK_EN.
module sseg_score_display #(
  parameter int DIGIT_CYCLES      = 16250,
  parameter int BLINK_HALF_FRAMES = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] player1_score,
  input  logic [3:0] player2_score,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  function automatic logic tens_of(input logic [3:0] s);
    return (s >= 4'd10);
  endfunction

  function automatic logic [3:0] units_of(input logic [3:0] s);
    return s - (tens_of(s) ? 4'd10 : 4'd0);
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  // Input stage
  logic [3:0] p1_d, p1_q, p2_d, p2_q;
  logic       blank_d, blank_q;

  always_comb begin
    p1_d    = player1_score;
    p2_d    = player2_score;
    blank_d = blank;
  end

  always_ff @(posedge clk) begin
    p1_q    <= p1_d;
    p2_q    <= p2_d;
    blank_q <= blank_d;
  end

  // Refresh scan
  logic [CNT_W-1:0] div_cnt_d, div_cnt_q;
  logic [1:0]       dig_d, dig_q;
  logic             slot_end;

  always_comb begin
    slot_end  = (div_cnt_q == CNT_LAST);
    div_cnt_d = div_cnt_q + 1'b1;
    dig_d     = dig_q;
    if (slot_end) begin
      div_cnt_d = '0;
      dig_d     = dig_q + 2'd1;
    end
  end

  logic sup_p1, sup_p2;

`ifdef SSEG_SCORE_BLINK_EN
  localparam int FC_W = (BLINK_HALF_FRAMES > 1) ? $clog2(BLINK_HALF_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_HALF_FRAMES - 1);

  // Index 1 is player 1, index 0 is player 2.
  logic [3:0]                p1_prev_q, p2_prev_q;
  logic [1:0]                chg;
  logic                      frame_tick;
  logic [1:0]                bl_act_d, bl_act_q;
  logic [1:0][1:0]           bl_hp_d, bl_hp_q;
  logic [1:0][FC_W-1:0]      bl_fc_d, bl_fc_q;

  always_comb begin
    frame_tick = slot_end && (dig_q == 2'd3);
    chg        = {p1_q != p1_prev_q, p2_q != p2_prev_q};
    bl_act_d   = bl_act_q;
    bl_hp_d    = bl_hp_q;
    bl_fc_d    = bl_fc_q;
    for (int i = 0; i < 2; i++) begin
      if (chg[i]) begin
        bl_act_d[i] = 1'b1;
        bl_hp_d[i]  = 2'd0;
        bl_fc_d[i]  = '0;
      end else if (bl_act_q[i] && frame_tick) begin
        if (bl_fc_q[i] == FC_LAST) begin
          bl_fc_d[i] = '0;
          if (bl_hp_q[i] == 2'd3) bl_act_d[i] = 1'b0;
          else                    bl_hp_d[i]  = bl_hp_q[i] + 2'd1;
        end else begin
          bl_fc_d[i] = bl_fc_q[i] + 1'b1;
        end
      end
    end
    // Odd half-periods are the dark phases of the blink.
    sup_p1 = bl_act_q[1] && bl_hp_q[1][0];
    sup_p2 = bl_act_q[0] && bl_hp_q[0][0];
  end

  always_ff @(posedge clk) begin
    p1_prev_q <= p1_q;
    p2_prev_q <= p2_q;
    if (rst) begin
      bl_act_q <= '0;
      bl_hp_q  <= '0;
      bl_fc_q  <= '0;
    end else begin
      bl_act_q <= bl_act_d;
      bl_hp_q  <= bl_hp_d;
      bl_fc_q  <= bl_fc_d;
    end
  end
`else
  always_comb begin
    sup_p1 = 1'b0;
    sup_p2 = 1'b0;
  end
`endif

  // Output stage
  logic [6:0] seg_d, seg_q;
  logic [3:0] an_d, an_q, an_sel;
  logic       dp_d, dp_q, lit;
  logic [3:0] digit;

  always_comb begin
    digit  = 4'd0;
    lit    = 1'b0;
    an_sel = 4'b1111;
    case (dig_q)
      2'd0: begin
        digit  = units_of(p2_q);
        lit    = !sup_p2;
        an_sel = 4'b1110;
      end
      2'd1: begin
        digit  = {3'b000, tens_of(p2_q)};
        lit    = tens_of(p2_q) && !sup_p2;
        an_sel = 4'b1101;
      end
      2'd2: begin
        digit  = units_of(p1_q);
        lit    = !sup_p1;
        an_sel = 4'b1011;
      end
      default: begin
        digit  = {3'b000, tens_of(p1_q)};
        lit    = tens_of(p1_q) && !sup_p1;
        an_sel = 4'b0111;
      end
    endcase
    seg_d = seg_code(digit);
    // The first cycle of every slot stays dark so the previous digit cannot ghost.
    an_d  = (lit && !blank_q && (div_cnt_q != '0)) ? an_sel : 4'b1111;
    dp_d  = !((dig_q == 2'd2) && !blank_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      dig_q     <= 2'd0;
      seg_q     <= 7'b1111111;
      an_q      <= 4'b1111;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_sseg_score_display.sv
// Directed bench for sseg_score_display with a 4-cycle slot and 2-frame blink half-period.
module tb_sseg_score_display;

  localparam int DC  = 4;
  localparam int BHF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] p1 = 4'd0, p2 = 4'd0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  sseg_score_display #(.DIGIT_CYCLES(DC), .BLINK_HALF_FRAMES(BHF)) dut (
    .clk(clk), .rst(rst), .player1_score(p1), .player2_score(p2),
    .blank(blank), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      p1;
    logic [3:0]      p2;
    logic [3:0][3:0] an;
    logic [3:0][6:0] sg;
  } vec_t;

  vec_t vecs [8];

  logic [6:0] SEGS [10];

  int checks = 0;
  int errors = 0;
  int k = 0;
  int f1 = -1, f2 = -1;
  logic [3:0] p1_h1 = 0, p1_h2 = 0, p2_h1 = 0, p2_h2 = 0;
  logic       b_h1 = 0, b_h2 = 0;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %b want %b", nm, k, act, exp);
    end
  endtask

  task automatic step();
    logic r;
    r = rst;
    p1_h2 = p1_h1; p1_h1 = p1;
    p2_h2 = p2_h1; p2_h1 = p2;
    b_h2  = b_h1;  b_h1  = blank;
    @(posedge clk);
    if (r) begin
      k = 0; f1 = -1; f2 = -1;
    end else begin
      k++;
      if (f1 == -2) f1 = 0; else if (f1 >= 0 && (k - 1) % 16 == 0) f1++;
      if (f2 == -2) f2 = 0; else if (f2 >= 0 && (k - 1) % 16 == 0) f2++;
    end
    @(negedge clk);
  endtask

  task automatic set_scores(input logic [3:0] a, input logic [3:0] b);
    if (a != p1) f1 = -2;
    if (b != p2) f2 = -2;
    p1 = a;
    p2 = b;
  endtask

  task automatic sync_to(input int ph);
    for (int i = 0; i < 16 && (k % 16) != ph; i++) step();
  endtask

  task automatic settle();
`ifdef SSEG_SCORE_BLINK_EN
    repeat (9 * 16) step();
`else
    repeat (2) step();
`endif
  endtask

  function automatic logic dark(input int f);
`ifdef SSEG_SCORE_BLINK_EN
    return (f >= 0) && (f < 8) && ((f % 4) >= 2);
`else
    return (f < -100);
`endif
  endfunction

  task automatic check_model(input string nm);
    int ph, d, dv;
    logic [3:0] ea, dg;
    logic l;
    ph = (k - 1) % 16; d = ph / 4; dv = ph % 4;
    case (d)
      0: begin dg = (p2_h2 >= 10) ? p2_h2 - 4'd10 : p2_h2; l = !dark(f2); end
      1: begin dg = (p2_h2 >= 10) ? 4'd1 : 4'd0; l = (p2_h2 >= 10) && !dark(f2); end
      2: begin dg = (p1_h2 >= 10) ? p1_h2 - 4'd10 : p1_h2; l = !dark(f1); end
      default: begin dg = (p1_h2 >= 10) ? 4'd1 : 4'd0; l = (p1_h2 >= 10) && !dark(f1); end
    endcase
    ea = (l && !b_h2 && dv != 0) ? ~(4'b0001 << d) : 4'b1111;
    chk({nm, "_an"}, {3'b000, an}, {3'b000, ea});
    chk({nm, "_dp"}, {6'b0, dp}, {6'b0, !(d == 2 && !b_h2)});
    chk({nm, "_seg"}, seg, SEGS[dg]);
  endtask

  task automatic check_frame(input vec_t v, input string nm);
    int ph, d, dv;
    for (int c = 0; c < 16; c++) begin
      step();
      ph = (k - 1) % 16; d = ph / 4; dv = ph % 4;
      chk({nm, "_an"}, {3'b000, an}, {3'b000, (dv == 0) ? 4'b1111 : v.an[d]});
      chk({nm, "_dp"}, {6'b0, dp}, {6'b0, (d == 2) ? 1'b0 : 1'b1});
      if (dv != 0 && v.an[d] != 4'b1111) chk({nm, "_seg"}, seg, v.sg[d]);
    end
  endtask

  initial begin
    SEGS = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vecs[0] = '{4'd11, 4'd11, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001}};
    vecs[1] = '{4'd12, 4'd7, {4'b0111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1111001, 7'b0100100, 7'b1000000, 7'b1111000}};
    vecs[2] = '{4'd0, 4'd15, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000000, 7'b1000000, 7'b1111001, 7'b0010010}};
    vecs[3] = '{4'd9, 4'd10, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000000, 7'b0010000, 7'b1111001, 7'b1000000}};
    vecs[4] = '{4'd15, 4'd0, {4'b0111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1111001, 7'b0010010, 7'b1000000, 7'b1000000}};
    vecs[5] = '{4'd8, 4'd4, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1000000, 7'b0000000, 7'b1000000, 7'b0011001}};
    vecs[6] = '{4'd13, 4'd6, {4'b0111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1111001, 7'b0110000, 7'b1000000, 7'b0000010}};
    vecs[7] = '{4'd13, 4'd9, {4'b0111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1111001, 7'b0110000, 7'b1000000, 7'b0010000}};

    // Reset values, then the first frame after release
    rst = 1'b1; p1 = 4'd11; p2 = 4'd11;
    repeat (3) begin
      step();
      chk("rst_an", {3'b000, an}, 7'b0001111);
      chk("rst_seg", seg, 7'b1111111);
      chk("rst_dp", {6'b0, dp}, 7'b0000001);
    end
    rst = 1'b0;
    check_frame(vecs[0], "first_frame");

    for (int i = 1; i < 7; i++) begin
      set_scores(vecs[i].p1, vecs[i].p2);
      settle();
      sync_to(0);
      check_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Two-cycle score latency inside a lit p2-units slot (6 -> 9)
    sync_to(1);
    set_scores(4'd13, 4'd9);
    step();
    chk("lat_old_seg", seg, 7'b0000010);
    step();
    chk("lat_new_seg", seg, 7'b0010000);

    // Blank for 20 cycles mid-frame
    sync_to(5);
    blank = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      if (i == 21) blank = 1'b0;
      step();
      if (i >= 2 && i <= 21) begin
        chk("blank_an", {3'b000, an}, 7'b0001111);
        chk("blank_dp", {6'b0, dp}, 7'b0000001);
      end else begin
        check_model("blank_edge");
      end
    end

    // Reset pulse during dig=2
    settle();
    sync_to(9);
    step();
    rst = 1'b1;
    step();
    chk("midrst_an", {3'b000, an}, 7'b0001111);
    chk("midrst_seg", seg, 7'b1111111);
    chk("midrst_dp", {6'b0, dp}, 7'b0000001);
    rst = 1'b0;
    check_frame(vecs[7], "after_midrst");

`ifdef SSEG_SCORE_BLINK_EN
    begin
      bit p2_done, p1_done;
      p2_done = 0; p1_done = 0;
      set_scores(4'd3, 4'd5);
      settle();
      sync_to(5);
      set_scores(4'd4, 4'd5);
      for (int i = 0; i < 22 * 16; i++) begin
        if (!p2_done && f1 == 3 && (k % 16) == 5) begin set_scores(4'd4, 4'd6); p2_done = 1; end
        else if (!p1_done && f1 == 6 && (k % 16) == 5) begin set_scores(4'd7, 4'd6); p1_done = 1; end
        step();
        check_model("blink");
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
